// File: rtl/uart_msg_sequencer.sv
// Byte sequencer: holds a small message buffer and presents it byte by byte to
// a UART transmitter over valid/ready, with optional inter-byte gap, repeat and abort.
module uart_msg_sequencer #(
  parameter int MSG_LEN    = 16,
  parameter int ADDR_W     = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W:0]   len,
  input  logic              start,
  input  logic              repeat_en,
  input  logic              abort,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] byte_idx
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    GAP   = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] MSG_LEN_W = (ADDR_W + 1)'(MSG_LEN);
  localparam logic [15:0]     GAP_LAST  = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  logic [7:0]        mem_r [MSG_LEN];
  state_t            state_r, state_s;
  logic [ADDR_W:0]   len_r, len_s;
  logic [ADDR_W-1:0] idx_s;
  logic [7:0]        data_s;
  logic [15:0]       gap_r, gap_s;
  logic              abort_r, abort_s, abort_any_s, last_s, xfer_s;

  // Buffer write port; contents survive reset and are only writable while idle
  always_ff @(posedge clk) begin
    if (wr_en && (state_r == IDLE) && ({1'b0, wr_addr} < MSG_LEN_W)) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Next-state and next-value logic for the sequencer
  always_comb begin
    state_s     = state_r;
    len_s       = len_r;
    idx_s       = byte_idx;
    data_s      = tx_data;
    gap_s       = gap_r;
    abort_any_s = abort_r | abort;
    abort_s     = (state_r != IDLE) & abort_any_s;
    last_s      = (({1'b0, byte_idx} + (ADDR_W + 1)'(1)) >= len_r);
    xfer_s      = (state_r == SEND) && tx_ready;
    case (state_r)
      IDLE: begin
        if (start) begin
          len_s   = (len > MSG_LEN_W) ? MSG_LEN_W : len;
          idx_s   = {ADDR_W{1'b0}};
          state_s = (len == {(ADDR_W + 1){1'b0}}) ? FIN : FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (abort_any_s) begin
          state_s = FIN;
        end else begin
          data_s  = mem_r[byte_idx];
          state_s = SEND;
        end
      end
      SEND: begin
        if (!xfer_s) begin
          state_s = SEND;
        end else if (abort_any_s) begin
          state_s = FIN;
        end else if (GAP_CYCLES > 0) begin
          gap_s   = 16'd0;
          state_s = GAP;
        end else if (last_s) begin
          state_s = FIN;
        end else begin
          idx_s   = byte_idx + ADDR_W'(1);
          state_s = FETCH;
        end
      end
      GAP: begin
        if (abort_any_s) begin
          state_s = FIN;
        end else if (gap_r != GAP_LAST) begin
          gap_s = gap_r + 16'd1;
        end else if (last_s) begin
          state_s = FIN;
        end else begin
          idx_s   = byte_idx + ADDR_W'(1);
          state_s = FETCH;
        end
      end
      FIN: begin
        // A zero-length pass never loops, even with repeat_en held
        if (repeat_en && !abort_any_s && (len_r != {(ADDR_W + 1){1'b0}})) begin
          idx_s   = {ADDR_W{1'b0}};
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      len_r    <= {(ADDR_W + 1){1'b0}};
      gap_r    <= 16'd0;
      abort_r  <= 1'b0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_idx <= {ADDR_W{1'b0}};
    end else begin
      state_r  <= state_s;
      len_r    <= len_s;
      gap_r    <= gap_s;
      abort_r  <= abort_s;
      tx_data  <= data_s;
      tx_valid <= (state_s == SEND);
      busy     <= (state_s != IDLE);
      done     <= (state_s == FIN);
      byte_idx <= idx_s;
    end
  end

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Self-checking bench for uart_msg_sequencer: directed scenarios plus randomized
// passes compared against a buffer/queue reference model.
module tb_uart_msg_sequencer;

  localparam int MSG_LEN = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic [7:0] wr_data = 8'd0;
  logic [4:0] len = 5'd0;
  logic       start = 1'b0, repeat_en = 1'b0, abort = 1'b0, tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid, busy, done;
  logic [3:0] byte_idx;

  logic       g_wr_en = 1'b0;
  logic [3:0] g_wr_addr = 4'd0;
  logic [7:0] g_wr_data = 8'd0;
  logic [4:0] g_len = 5'd0;
  logic       g_start = 1'b0, g_tx_ready = 1'b0;
  logic [7:0] g_tx_data;
  logic       g_tx_valid, g_busy, g_done;
  logic [3:0] g_byte_idx;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] mem_m [MSG_LEN];
  logic [7:0] got_q[$];
  int         xq[$];
  int         done_cnt, valid_cnt, cyc;
  logic       prev_v, prev_r, prev_rst;
  logic [7:0] prev_d;
  logic [7:0] g_got[$];
  int         g_xq[$];
  int         g_done_cnt;

  uart_msg_sequencer #(.MSG_LEN(16), .ADDR_W(4), .GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .start(start), .repeat_en(repeat_en), .abort(abort),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .byte_idx(byte_idx)
  );

  uart_msg_sequencer #(.MSG_LEN(16), .ADDR_W(4), .GAP_CYCLES(3)) dut_gap (
    .clk(clk), .rst(rst), .wr_en(g_wr_en), .wr_addr(g_wr_addr), .wr_data(g_wr_data),
    .len(g_len), .start(g_start), .repeat_en(1'b0), .abort(1'b0),
    .tx_data(g_tx_data), .tx_valid(g_tx_valid), .tx_ready(g_tx_ready),
    .busy(g_busy), .done(g_done), .byte_idx(g_byte_idx)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observes handshakes away from the clock edge; a transfer seen here lands on the next posedge
  always @(negedge clk) begin
    cyc++;
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      got_q.push_back(tx_data);
      xq.push_back(cyc);
    end
    if (tx_valid === 1'b1) valid_cnt++;
    if (done === 1'b1) done_cnt++;
    if (prev_v === 1'b1 && prev_r === 1'b0 && prev_rst === 1'b0) begin
      check_eq("hold_valid", tx_valid, 1);
      check_eq("hold_data", tx_data, prev_d);
    end
    prev_v = tx_valid; prev_r = tx_ready; prev_d = tx_data; prev_rst = rst;
    if (g_tx_valid === 1'b1 && g_tx_ready === 1'b1) begin
      g_got.push_back(g_tx_data);
      g_xq.push_back(cyc);
    end
    if (g_done === 1'b1) g_done_cnt++;
  end

  task automatic clear_mon();
    got_q.delete(); xq.delete();
    done_cnt = 0; valid_cnt = 0;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic wait_idle(input int budget);
    int guard = 0;
    while (busy && guard < budget) begin tick(); guard++; end
    check_eq("idle_timeout", guard < budget, 1);
  endtask

  task automatic run_pass(input int ln, input int pct, input int stall_idx, input int stall_len,
                          input bit chk_rate);
    int  n, left, guard;
    bit  prev_done;
    n = (ln > MSG_LEN) ? MSG_LEN : ln;
    clear_mon();
    len = 5'(ln); start = 1'b1; tx_ready = 1'b0;
    tick();
    start = 1'b0;
    check_eq("lat0_valid", tx_valid, 0);
    check_eq("lat0_busy", busy, 1);
    tick();
    check_eq("lat1_valid", tx_valid, 1);
    check_eq("lat1_data", tx_data, mem_m[0]);
    left = stall_len; guard = 0; prev_done = 1'b0;
    while (busy && guard < 2000) begin
      if (tx_valid && int'(byte_idx) == stall_idx && left > 0) begin
        check_eq("stall_data", tx_data, mem_m[stall_idx]);
        tx_ready = 1'b0;
        left--;
      end else begin
        tx_ready = ($urandom_range(99) < pct);
      end
      prev_done = done;
      tick();
      guard++;
    end
    tx_ready = 1'b0;
    check_eq("pass_timeout", guard < 2000, 1);
    check_eq("busy_after_done", prev_done, 1);
    check_eq("nbytes", got_q.size(), n);
    for (int k = 0; k < n && k < got_q.size(); k++) check_eq("byte", got_q[k], mem_m[k]);
    check_eq("done_cnt", done_cnt, 1);
    if (chk_rate)
      for (int k = 1; k < xq.size(); k++) check_eq("rate", xq[k] - xq[k-1], 2);
  endtask

  initial begin
    logic [7:0] msg [10];
    int         guard;
    logic [7:0] g0, g1;
    msg = '{8'h61, 8'h6C, 8'h61, 8'h20, 8'h6D, 8'h61, 8'h20, 8'h70, 8'h73, 8'h61};
    cyc = 0; prev_v = 1'b0; prev_r = 1'b0; prev_rst = 1'b1; g_done_cnt = 0;
    clear_mon();

    repeat (3) tick();
    check_eq("rst_valid", tx_valid, 0);
    check_eq("rst_data", tx_data, 8'h00);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_idx", byte_idx, 0);
    rst = 1'b0;
    tick();

    for (int a = 0; a < 10; a++) wr(a, msg[a]);
    run_pass(10, 100, -1, 0, 1'b1);
    run_pass(10, 100, 3, 5, 1'b0);

    // Repeat: loop once more, then drop repeat_en during the second pass
    clear_mon();
    len = 5'd3; repeat_en = 1'b1; start = 1'b1; tx_ready = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (done_cnt < 1 && guard < 200) begin tick(); guard++; end
    repeat_en = 1'b0;
    wait_idle(200);
    check_eq("rep_nbytes", got_q.size(), 6);
    for (int k = 0; k < 6 && k < got_q.size(); k++) check_eq("rep_byte", got_q[k], mem_m[k % 3]);
    check_eq("rep_done", done_cnt, 2);

    // Abort while byte 1 is stalled in SEND
    clear_mon();
    len = 5'd10; start = 1'b1; tx_ready = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!(tx_valid && byte_idx == 4'd1) && guard < 100) begin tick(); guard++; end
    check_eq("abort_reach", guard < 100, 1);
    tx_ready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    tx_ready = 1'b1;
    wait_idle(100);
    tx_ready = 1'b0;
    check_eq("abort_nbytes", got_q.size(), 2);
    for (int k = 0; k < 2 && k < got_q.size(); k++) check_eq("abort_byte", got_q[k], mem_m[k]);
    check_eq("abort_done", done_cnt, 1);

    // Zero length
    clear_mon();
    len = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("len0_done", done, 1);
    tick();
    check_eq("len0_busy", busy, 0);
    repeat (3) tick();
    check_eq("len0_valid_cnt", valid_cnt, 0);
    check_eq("len0_done_cnt", done_cnt, 1);

    // Writes while busy must not reach the buffer
    len = 5'd4; start = 1'b1; tx_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wr_en = 1'b1; wr_addr = 4'(k % 4); wr_data = 8'hEE;
      tick();
    end
    wr_en = 1'b0;
    wait_idle(100);
    run_pass(4, 100, -1, 0, 1'b1);

    // Reset in the middle of SEND
    len = 5'd5; start = 1'b1; tx_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    check_eq("pre_rst_valid", tx_valid, 1);
    rst = 1'b1;
    tick();
    check_eq("mrst_valid", tx_valid, 0);
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_idx", byte_idx, 0);
    rst = 1'b0;
    tick();
    run_pass(5, 100, -1, 0, 1'b1);

    // Inter-byte gap on the GAP_CYCLES=3 instance
    g0 = 8'($urandom); g1 = 8'($urandom);
    g_wr_en = 1'b1; g_wr_addr = 4'd0; g_wr_data = g0; tick();
    g_wr_addr = 4'd1; g_wr_data = g1; tick();
    g_wr_en = 1'b0;
    g_len = 5'd2; g_start = 1'b1; g_tx_ready = 1'b1;
    tick();
    g_start = 1'b0;
    guard = 0;
    while (g_busy && guard < 100) begin tick(); guard++; end
    check_eq("gap_timeout", guard < 100, 1);
    check_eq("gap_nbytes", g_got.size(), 2);
    if (g_got.size() == 2) begin
      check_eq("gap_b0", g_got[0], g0);
      check_eq("gap_b1", g_got[1], g1);
      check_eq("gap_spacing", g_xq[1] - g_xq[0], 2 + 3);
    end
    check_eq("gap_done", g_done_cnt, 1);

    // Clamp: len above MSG_LEN sends the whole buffer
    for (int a = 10; a < 16; a++) wr(a, 8'($urandom));
    run_pass(20, 100, -1, 0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      int ln, pct;
      for (int a = 0; a < 16; a++) wr(a, 8'($urandom));
      ln  = $urandom_range(20, 1);
      pct = $urandom_range(100, 30);
      run_pass(ln, pct, -1, 0, pct == 100);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
